// File: rtl/if_fetch.sv
// Instruction-fetch stage: issues in-order imem requests from the pc_gen
// stream, buffers responses with their PCs and hands them to decode.
module if_fetch #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic        core_clk,
    input  logic        core_rst_n,
    input  logic [63:0] pc,
    input  logic        pc_valid,
    input  logic        flush,
    output logic        pc_pause,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic        id_valid,
    output logic [63:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_fault,
    input  logic        id_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int SW = CNT_W + 2;
    localparam logic [SW-1:0]    DEPTH_S = SW'(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Counters: outstanding requests, buffered entries, responses to drop
    logic [CNT_W-1:0] r_out;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_kill;

    // PC-tag queue for granted requests awaiting a response
    logic [63:0]   r_tag [DEPTH];
    logic [PW-1:0] r_tag_wp;
    logic [PW-1:0] r_tag_rp;

    // Decode-side FIFO storage
    logic [63:0]   r_fpc   [DEPTH];
    logic [31:0]   r_finst [DEPTH];
    logic          r_fflt  [DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;

    logic [SW-1:0]    w_sum;
    logic             w_space;
    logic             w_aligned;
    logic             w_go;
    logic             w_mis;
    logic             w_fire;
    logic             w_rv_kill;
    logic             w_rv_take;
    logic             w_push;
    logic             w_pop;
    logic [63:0]      w_push_pc;
    logic [31:0]      w_push_inst;
    logic             w_push_flt;
    logic [CNT_W-1:0] w_out_dec;
    logic [CNT_W-1:0] w_kill_dec;

    // Credit check and request/consume decisions for the current PC
    always_comb begin
        w_sum     = SW'(r_out) + SW'(r_cnt) + SW'(r_kill);
        w_space   = w_sum < DEPTH_S;
        w_aligned = pc[1:0] == 2'b00;
        w_go      = core_rst_n & pc_valid & ~flush & w_space;
        imem_req  = w_go & w_aligned;
        imem_addr = pc;
        w_mis     = w_go & ~w_aligned
                  & (r_out == '0) & (r_kill == '0);
        w_fire    = imem_req & imem_gnt;
        pc_pause  = core_rst_n & pc_valid & ~(w_fire | w_mis);
    end

    // Response routing, FIFO push/pop and head presentation
    always_comb begin
        w_rv_kill   = imem_rvalid & (r_kill != '0);
        w_rv_take   = imem_rvalid & (r_kill == '0);
        w_push      = ~flush & (w_rv_take | w_mis);
        w_push_pc   = w_mis ? pc : r_tag[r_tag_rp];
        w_push_flt  = w_mis | imem_err;
        w_push_inst = w_push_flt ? 32'h0 : imem_rdata;
        w_out_dec   = r_out - CNT_W'(w_rv_take);
        w_kill_dec  = r_kill - CNT_W'(w_rv_kill);
        id_valid    = r_cnt != '0;
        id_pc       = r_fpc[r_rp];
        id_inst     = r_finst[r_rp];
        id_fault    = r_fflt[r_rp];
        w_pop       = id_valid & id_ready;
    end

    // Counter updates; a flush turns all in-flight work into drops
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            r_out  <= '0;
            r_cnt  <= '0;
            r_kill <= '0;
        end else if (flush) begin
            r_out  <= '0;
            r_cnt  <= '0;
            r_kill <= w_kill_dec + w_out_dec;
        end else begin
            r_out  <= w_out_dec + CNT_W'(w_fire);
            r_kill <= w_kill_dec;
            r_cnt  <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Tag queue: push on grant, pop on an accepted response
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            r_tag_wp <= '0;
            r_tag_rp <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_tag[i] <= '0;
            end
        end else if (flush) begin
            r_tag_wp <= '0;
            r_tag_rp <= '0;
        end else begin
            if (w_fire) begin
                r_tag[r_tag_wp] <= pc;
                r_tag_wp        <= r_tag_wp + PW'(1);
            end
            if (w_rv_take) begin
                r_tag_rp <= r_tag_rp + PW'(1);
            end
        end
    end

    // Decode FIFO: responses and misaligned faults in, decode pops out
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            r_wp <= '0;
            r_rp <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fpc[i]   <= '0;
                r_finst[i] <= '0;
                r_fflt[i]  <= 1'b0;
            end
        end else if (flush) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push) begin
                r_fpc[r_wp]   <= w_push_pc;
                r_finst[r_wp] <= w_push_inst;
                r_fflt[r_wp]  <= w_push_flt;
                r_wp          <= r_wp + PW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + PW'(1);
            end
        end
    end

    a_rv_orphan: assert property (
        @(posedge core_clk) disable iff (!core_rst_n)
        imem_rvalid |-> (r_out != '0 || r_kill != '0));

    a_cnt_max: assert property (
        @(posedge core_clk) disable iff (!core_rst_n)
        r_cnt <= DEPTH_C);

    a_push_full: assert property (
        @(posedge core_clk) disable iff (!core_rst_n)
        (w_push && r_cnt == DEPTH_C) |-> w_pop);

endmodule
